// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SLL  = 3'b001;
  localparam logic [2:0] SLT  = 3'b010;
  localparam logic [2:0] SLTU = 3'b011;
  localparam logic [2:0] XOR  = 3'b100;
  localparam logic [2:0] SRL  = 3'b101;
  localparam logic [2:0] OR   = 3'b110;
  localparam logic [2:0] AND  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Operation request / result handshake bundle for alu_seq.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic             alt;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, opcode, alt, left, right, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, opcode, alt, left, right, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/alu_logic.sv
// Single-cycle ALU operations; shift opcodes pass left through and are sequenced by alu_seq.
module alu_logic
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       opcode,
  input  logic             alt,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = left;
    case (opcode)
      ADD:     y = alt ? (left - right) : (left + right);
      SLT:     y = {{(WIDTH-1){1'b0}}, ($signed(left) < $signed(right))};
      SLTU:    y = {{(WIDTH-1){1'b0}}, (left < right)};
      XOR:     y = left ^ right;
      OR:      y = left | right;
      AND:     y = left & right;
      default: y = left;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops via alu_logic, shifts one bit per clock.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  state_e             state;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   work_nxt;
  logic [WIDTH-1:0]   logic_y;
  logic [SHAMT_W-1:0] cnt_q;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid_q;
  logic               shl_q;
  logic               sra_q;
  logic               accept;
  logic               is_shift;

  alu_logic #(.WIDTH(WIDTH)) u_logic (
    .opcode (bus.opcode),
    .alt    (bus.alt),
    .left   (bus.left),
    .right  (bus.right),
    .y      (logic_y)
  );

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign shamt    = bus.right[SHAMT_W-1:0];
  assign is_shift = (bus.opcode == SLL) || (bus.opcode == SRL);
  // Fill bit is the sign only for SRA; SLL and SRL shift in zeros.
  assign work_nxt = shl_q ? (work_q << 1) : {sra_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      shl_q       <= 1'b0;
      sra_q       <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          work_q <= work_nxt;
          cnt_q  <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            result_q    <= work_nxt;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        default: begin
          // IDLE and DONE share acceptance so DONE can take a new op in the release edge.
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              work_q      <= bus.left;
              cnt_q       <= shamt;
              shl_q       <= (bus.opcode == SLL);
              sra_q       <= (bus.opcode == SRL) && bus.alt;
              out_valid_q <= 1'b0;
              state       <= SHIFT;
            end else begin
              result_q    <= is_shift ? bus.left : logic_y;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end else if ((state == DONE) && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH SHALL default to 32 and sets the operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 Parameter SHAMT_W SHALL default to $clog2(WIDTH) and sets the width of the shift amount; it is not overridden.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  an operation is presented on opcode/alt/left/right.
REQ-006 in_ready  output  1  the block accepts an operation this cycle.
REQ-007 opcode  input  3  operation select (see REQ-012).
REQ-008 alt  input  1  variant select: SUB instead of ADD, SRA instead of SRL; ignored for other opcodes.
REQ-009 left  input  WIDTH  first operand.
REQ-010 right  input  WIDTH  second operand; bits [SHAMT_W-1:0] are the shift amount for shifts.
REQ-011 out_valid / out_ready / result  output / input / output  1 / 1 / WIDTH  result handshake and registered result.

Function
REQ-012 Opcodes SHALL be: ADD=000 (SUB if alt), SLL=001, SLT=010 (signed), SLTU=011, XOR=100, SRL=101 (SRA if alt), OR=110, AND=111.
REQ-013 Arithmetic SHALL be modulo 2^WIDTH, with carry and overflow discarded; SLT/SLTU SHALL return 1 or 0 zero-extended to WIDTH.
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE, and the FSM SHALL be in IDLE after reset.
REQ-015 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1; it SHALL be 0 in SHIFT.
REQ-016 An operation is accepted on a rising edge with in_valid=1 and in_ready=1; opcode, alt, left and right SHALL be captured at that edge.
REQ-017 A non-shift operation SHALL load result at the acceptance edge and enter DONE, so out_valid is 1 in the following cycle (latency 1).
REQ-018 A shift with amount k=0 SHALL behave as REQ-017, with result=left.
REQ-019 A shift with amount k>0 SHALL load left into a working register and k into a counter, then enter SHIFT.
REQ-020 In SHIFT, each edge SHALL shift the working register by one bit and decrement the counter; at the edge where the counter is 1, the working register SHALL be copied to result and the FSM SHALL enter DONE (latency k+1).
REQ-021 SRA SHALL replicate the sign bit on each step; SRL and SLL SHALL shift in zeros.
REQ-022 In DONE, out_valid SHALL be 1 and result SHALL be held stable until an edge with out_ready=1.
REQ-023 On an edge in DONE with out_ready=1 and in_valid=0, the FSM SHALL return to IDLE and out_valid SHALL fall.
REQ-024 On an edge in DONE with out_ready=1 and in_valid=1, the new operation SHALL be accepted in the same edge (back-to-back; REQ-017 to REQ-019 apply), giving a throughput of one non-shift operation per cycle.
REQ-025 Inputs SHALL be ignored while in SHIFT, and while in DONE with out_ready=0.

Reset
REQ-026 While rst_n=0 the outputs SHALL be: state IDLE, out_valid=0, result=0, in_ready=1, working register and counter 0.
REQ-027 Reset asserted mid-operation (in SHIFT or DONE) SHALL drop the operation; no out_valid SHALL be produced for it.
REQ-028 The first acceptance SHALL be possible at the first rising edge after rst_n deasserts.

Structure
REQ-029 Package alu_pkg SHALL hold the opcode constants (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND) and the state enum {IDLE, SHIFT, DONE}.
REQ-030 Single-cycle operations SHALL live in one combinational sub-module, alu_logic (parameter WIDTH; ports opcode, alt, left, right, y); the FSM, shifter and registers SHALL live in alu_seq.

Verification (WIDTH=32)
REQ-031 ADD then SUB: ADD 0xFFFFFFFF+1 -> result 0x00000000 one cycle later; SUB 5-7 -> 0xFFFFFFFE.
REQ-032 SLT(0x80000000,1) -> 1; SLTU(0x80000000,1) -> 0.
REQ-033 SRA 0x80000000 by 4 -> 0xF8000000 with out_valid exactly 5 cycles after acceptance; in_ready=0 in between; SLL by 0 -> left after 1 cycle.
REQ-034 Back-to-back: in_valid and out_ready held at 1 with AND, OR, XOR -> three results on consecutive cycles.
REQ-035 Backpressure: out_ready=0 for 3 cycles in DONE -> result and out_valid stable, new inputs ignored; out_ready=1 -> released.
REQ-036 Reset mid-shift: SLL by 20, rst_n low at cycle 6 -> out_valid=0, result=0; after release, ADD 2+3 -> 5.
